// File: rtl/output_reorder_if.sv
// Stream bundle for output_reorder: bit-reversed input beats and natural-order output beats.
// Data layout is a packed complex sample {re[DW/2-1:0], im[DW/2-1:0]}. OUT_REORDER_LAST_CHECK_EN adds in_last/frame_err.
interface output_reorder_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
`ifdef OUT_REORDER_LAST_CHECK_EN
  logic          in_last;
  logic          frame_err;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, frame_err
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, frame_err
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
`endif
endinterface

// File: rtl/output_reorder.sv
// Ping-pong bit-reversal reorder: frames arrive in bit-reversed order and leave in natural order.
// Optional framing check enabled by `define OUT_REORDER_LAST_CHECK_EN (in_last / sticky frame_err).
module output_reorder #(
  parameter int N  = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  output_reorder_if.slave bus
);
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) begin
      r[i] = a[AW-1-i];
    end
    return r;
  endfunction

  logic [DW-1:0] mem_r [0:1][0:N-1];
  logic          wr_bank_r;
  logic          rd_bank_r;
  logic [AW-1:0] wr_cnt_r;
  logic [AW-1:0] rd_cnt_r;
  logic [1:0]    full_r;
  logic          wr_fire_s;
  logic          rd_fire_s;

  assign bus.in_ready  = ~full_r[wr_bank_r];
  assign bus.out_valid = full_r[rd_bank_r];
  assign bus.out_data  = mem_r[rd_bank_r][rd_cnt_r];
  assign bus.out_last  = full_r[rd_bank_r] && (rd_cnt_r == LAST_IDX);

  assign wr_fire_s = bus.in_valid && ~full_r[wr_bank_r];
  assign rd_fire_s = full_r[rd_bank_r] && bus.out_ready;

  // Sample storage; scattered to its natural slot as it arrives, never reset.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_r[wr_bank_r][bitrev(wr_cnt_r)] <= bus.in_data;
    end
  end

  // Bank pointers, beat counters and full flags; the two sides only ever own different banks.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_bank_r <= 1'b0;
      rd_bank_r <= 1'b0;
      wr_cnt_r  <= {AW{1'b0}};
      rd_cnt_r  <= {AW{1'b0}};
      full_r    <= 2'b00;
    end else begin
      if (wr_fire_s) begin
        if (wr_cnt_r == LAST_IDX) begin
          wr_cnt_r          <= {AW{1'b0}};
          full_r[wr_bank_r] <= 1'b1;
          wr_bank_r         <= ~wr_bank_r;
        end else begin
          wr_cnt_r <= wr_cnt_r + AW'(1);
        end
      end
      if (rd_fire_s) begin
        if (rd_cnt_r == LAST_IDX) begin
          rd_cnt_r          <= {AW{1'b0}};
          full_r[rd_bank_r] <= 1'b0;
          rd_bank_r         <= ~rd_bank_r;
        end else begin
          rd_cnt_r <= rd_cnt_r + AW'(1);
        end
      end
    end
  end

`ifdef OUT_REORDER_LAST_CHECK_EN
  logic frame_err_r;

  // Sticky flag: in_last must coincide exactly with the frame's final beat.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_err_r <= 1'b0;
    end else if (wr_fire_s && (bus.in_last != (wr_cnt_r == LAST_IDX))) begin
      frame_err_r <= 1'b1;
    end else begin
      frame_err_r <= frame_err_r;
    end
  end

  assign bus.frame_err = frame_err_r;
`endif

endmodule

// File: tb/tb_output_reorder.sv
// Randomised self-checking bench for output_reorder against a frame-queue reference model.
// Honours OUT_REORDER_LAST_CHECK_EN when defined.
module tb_output_reorder;
  localparam int N  = 8;
  localparam int DW = 32;
  localparam int AW = $clog2(N);

  logic clk;
  logic reset;

  output_reorder_if #(.DW(DW)) bus ();

  output_reorder #(.N(N), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: complete frames in natural order, plus the frame being filled.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] pend [N];
  int            wcnt    = 0;
  int            acc_cnt = 0;
  int            hs_cnt  = 0;
  int            bad_pos = -1;
  logic          exp_err = 1'b0;
  int            ready_drops = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int brev(input int k);
    int r = 0;
    int v = k;
    for (int i = 0; i < AW; i++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  task automatic drive_in(input logic v, input logic [DW-1:0] d);
    bus.in_valid = v;
    bus.in_data  = d;
`ifdef OUT_REORDER_LAST_CHECK_EN
    bus.in_last  = (bad_pos >= 0) ? (wcnt == bad_pos) : (wcnt == N - 1);
`endif
  endtask

  // One clock: check outputs at negedge, advance the model, return at posedge+1.
  task automatic step();
    int   used;
    logic exp_ready, exp_valid, acc, hs;
    @(negedge clk);
    used      = (exp_q.size() + N - 1) / N;
    exp_ready = (used < 2);
    exp_valid = (used > 0);
    if (reset) begin
      check_val("in_ready", bus.in_ready, exp_ready);
      check_val("out_valid", bus.out_valid, exp_valid);
      if (exp_valid) begin
        check_val("out_data", bus.out_data, exp_q[0]);
        check_val("out_last", bus.out_last, (exp_q.size() % N) == 1);
      end else begin
        check_val("out_last_idle", bus.out_last, 1'b0);
      end
`ifdef OUT_REORDER_LAST_CHECK_EN
      check_val("frame_err", bus.frame_err, exp_err);
`endif
      if (!exp_ready) ready_drops++;
      acc = bus.in_valid && exp_ready;
      hs  = exp_valid && bus.out_ready;
      if (hs) begin
        void'(exp_q.pop_front());
        hs_cnt++;
      end
      if (acc) begin
        pend[brev(wcnt)] = bus.in_data;
`ifdef OUT_REORDER_LAST_CHECK_EN
        if (bus.in_last != (wcnt == N - 1)) exp_err = 1'b1;
`endif
        wcnt++;
        acc_cnt++;
        if (wcnt == N) begin
          for (int i = 0; i < N; i++) exp_q.push_back(pend[i]);
          wcnt = 0;
        end
      end
    end else begin
      exp_q.delete();
      wcnt    = 0;
      exp_err = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int budget = 4 * N;
    drive_in(1'b0, '0);
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    check_val("drain_empty", exp_q.size(), 0);
  endtask

  task automatic run_random(input int cycles, input int p_in, input int p_out);
    for (int c = 0; c < cycles; c++) begin
      drive_in($urandom_range(99) < p_in, $urandom);
      bus.out_ready = ($urandom_range(99) < p_out);
      step();
    end
  endtask

  int basic_re [N] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int a0, h0;

  initial begin
    reset         = 1'b0;
    bus.out_ready = 1'b0;
    drive_in(1'b0, '0);
    step();
    step();
    reset = 1'b1;
    step();

    // Basic reorder of a directed frame.
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      drive_in(1'b1, DW'(basic_re[i]) << (DW / 2));
      step();
    end
    drive_in(1'b0, '0);
    check_val("basic_latency_valid", bus.out_valid, 1'b1);
    check_val("basic_first_re", bus.out_data >> (DW / 2), 0);
    drain();

    // Back-to-back: three frames streamed with no stalls.
    ready_drops = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3 * N; i++) begin
      drive_in(1'b1, $urandom);
      step();
    end
    check_val("b2b_ready_drops", ready_drops, 0);
    drain();

    // Backpressure: 17 offers, only two frames fit.
    bus.out_ready = 1'b0;
    a0 = acc_cnt;
    for (int i = 0; i < 2 * N + 1; i++) begin
      drive_in(1'b1, $urandom);
      step();
    end
    check_val("bp_accepted", acc_cnt - a0, 2 * N);
    drive_in(1'b0, '0);
    bus.out_ready = 1'b1;
    h0 = hs_cnt;
    for (int i = 0; i < N; i++) step();
    check_val("bp_handshakes", hs_cnt - h0, N);
    check_val("bp_ready_back", bus.in_ready, 1'b1);
    drain();

    // Random stalls on both sides.
    run_random(300, 70, 50);
    run_random(200, 90, 85);
    drain();

    // Reset while frame 1 drains and frame 2 is partly written.
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      drive_in(1'b1, $urandom);
      step();
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_in(1'b1, $urandom);
      step();
    end
    drive_in(1'b0, '0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    check_val("rst_out_valid", bus.out_valid, 1'b0);
    check_val("rst_in_ready", bus.in_ready, 1'b1);
    for (int i = 0; i < N; i++) begin
      drive_in(1'b1, $urandom);
      step();
    end
    drain();

`ifdef OUT_REORDER_LAST_CHECK_EN
    // Early in_last on the 6th beat sets a sticky error; data still reorders.
    bad_pos = 5;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      drive_in(1'b1, $urandom);
      step();
    end
    bad_pos = -1;
    check_val("err_set", bus.frame_err, 1'b1);
    run_random(40, 80, 80);
    drain();
    check_val("err_sticky", bus.frame_err, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
